// File: rtl/stream_demux_1to2_pkg.sv
// Shared datapath constants and helpers for the 1-to-2 stream demultiplexer.
// Channel buffers are two entries deep, so occupancy needs a 2-bit count (0..2).
package stream_demux_1to2_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } chan_sel_e;

  // Push-only increments, pop-only decrements, anything else holds.
  function automatic logic [CNT_W-1:0] next_count(
    input logic [CNT_W-1:0] cnt,
    input logic             push,
    input logic             pop
  );
    logic [CNT_W-1:0] res;
    res = cnt;
    case ({push, pop})
      2'b10:   res = cnt + CNT_W'(1);
      2'b01:   res = cnt - CNT_W'(1);
      default: res = cnt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/stream_demux_1to2_fifo2.sv
// Two-entry channel buffer: registered storage, 1-bit wrapping pointers, occupancy count.
// The head word comes straight from storage, so there is no path from data_i to data_o.
module demux_fifo2
  import stream_demux_1to2_pkg::*;
#(
  parameter int size  = DATA_W,
  parameter int depth = DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [size-1:0]  data_i,
  input  logic             pop_i,
  output logic [size-1:0]  data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(depth);

  logic [size-1:0]  mem_q [depth];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

  // Requests against a full or empty buffer are dropped here, so count never wraps.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign count_d = next_count(count_q, push_ok, pop_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/stream_demux_1to2.sv
// 1-to-2 stream demultiplexer: routes each accepted word to the channel named by select_i.
// Handshake: a word moves on any port exactly when its valid and ready are both high at a rising edge.
module stream_demux_1to2
  import stream_demux_1to2_pkg::*;
#(
  parameter int size  = DATA_W,
  parameter int depth = DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [size-1:0]  data_i,
  input  logic             valid_i,
  input  logic             select_i,
  output logic             ready_o,
  output logic [size-1:0]  data0_o,
  output logic             valid0_o,
  input  logic             ready0_i,
  output logic [CNT_W-1:0] count0_o,
  output logic [size-1:0]  data1_o,
  output logic             valid1_o,
  input  logic             ready1_i,
  output logic [CNT_W-1:0] count1_o
);

  logic full0;
  logic full1;
  logic empty0;
  logic empty1;
  logic accept;
  logic push0;
  logic push1;

  // Only the addressed buffer's fullness matters; downstream readies are not consulted.
  assign ready_o = (chan_sel_e'(select_i) == CH1) ? !full1 : !full0;
  assign accept  = valid_i && ready_o;
  assign push0   = accept && (chan_sel_e'(select_i) == CH0);
  assign push1   = accept && (chan_sel_e'(select_i) == CH1);

  assign valid0_o = !empty0;
  assign valid1_o = !empty1;

  demux_fifo2 #(
    .size  (size),
    .depth (depth)
  ) u_ch0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push0),
    .data_i  (data_i),
    .pop_i   (ready0_i),
    .data_o  (data0_o),
    .full_o  (full0),
    .empty_o (empty0),
    .count_o (count0_o)
  );

  demux_fifo2 #(
    .size  (size),
    .depth (depth)
  ) u_ch1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push1),
    .data_i  (data_i),
    .pop_i   (ready1_i),
    .data_o  (data1_o),
    .full_o  (full1),
    .empty_o (empty1),
    .count_o (count1_o)
  );

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed bench for stream_demux_1to2: per-channel expected queues drained by a monitor,
// plus explicit checks of ready, counts and reset behaviour.
module tb_stream_demux_1to2;
  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [W-1:0] data_i;
  logic         valid_i;
  logic         select_i;
  logic         ready_o;
  logic [W-1:0] data0_o;
  logic         valid0_o;
  logic         ready0_i;
  logic [1:0]   count0_o;
  logic [W-1:0] data1_o;
  logic         valid1_o;
  logic         ready1_i;
  logic [1:0]   count1_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];

  stream_demux_1to2 dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .select_i (select_i),
    .ready_o  (ready_o),
    .data0_o  (data0_o),
    .valid0_o (valid0_o),
    .ready0_i (ready0_i),
    .count0_o (count0_o),
    .data1_o  (data1_o),
    .valid1_o (valid1_o),
    .ready1_i (ready1_i),
    .count1_o (count1_o)
  );

  // clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic to_post();
    @(posedge clk_i);
    #1;
  endtask

  // Present one word for one cycle; exp_rdy is the hand-derived ready_o for that cycle.
  task automatic push_word(input logic sel, input logic [W-1:0] d, input logic exp_rdy);
    valid_i  = 1'b1;
    select_i = sel;
    data_i   = d;
    @(negedge clk_i);
    check("push_ready", {31'b0, ready_o}, {31'b0, exp_rdy});
    if (exp_rdy) begin
      if (sel) exp1_q.push_back(d);
      else     exp0_q.push_back(d);
    end
    to_post();
    valid_i = 1'b0;
  endtask

  // scoreboard monitor: pops expected word on every output transfer
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (valid0_o && ready0_i) begin
        if (exp0_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ch0_unexpected got %h expected none", data0_o);
        end else check("ch0_data", data0_o, exp0_q.pop_front());
      end
      if (valid1_o && ready1_i) begin
        if (exp1_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ch1_unexpected got %h expected none", data1_o);
        end else check("ch1_data", data1_o, exp1_q.pop_front());
      end
    end
  end

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; select_i = 1'b0; data_i = '0;
    ready0_i = 1'b1; ready1_i = 1'b1;
    to_post(); to_post();
    rst_i = 1'b0;

    // reset state
    @(negedge clk_i);
    check("rst_valid0", {31'b0, valid0_o}, 32'd0);
    check("rst_valid1", {31'b0, valid1_o}, 32'd0);
    check("rst_count0", {30'b0, count0_o}, 32'd0);
    check("rst_count1", {30'b0, count1_o}, 32'd0);
    check("rst_data0", data0_o, 32'd0);
    check("rst_data1", data1_o, 32'd0);
    check("rst_ready", {31'b0, ready_o}, 32'd1);
    to_post();

    // one word per channel, one cycle latency
    push_word(1'b0, 32'hA0000001, 1'b1);
    @(negedge clk_i);
    check("lat_valid0", {31'b0, valid0_o}, 32'd1);
    check("lat_data0", data0_o, 32'hA0000001);
    check("lat_count0", {30'b0, count0_o}, 32'd1);
    to_post();
    push_word(1'b1, 32'hB0000002, 1'b1);
    @(negedge clk_i);
    check("lat_data1", data1_o, 32'hB0000002);
    check("lat_count1", {30'b0, count1_o}, 32'd1);
    check("drain_count0", {30'b0, count0_o}, 32'd0);
    to_post();
    @(negedge clk_i);
    check("drain_count1", {30'b0, count1_o}, 32'd0);
    to_post();

    // fill channel 0 with consumer stalled
    ready0_i = 1'b0;
    push_word(1'b0, 32'h11, 1'b1);
    push_word(1'b0, 32'h22, 1'b1);
    push_word(1'b0, 32'h33, 1'b0);
    @(negedge clk_i);
    check("full_count0", {30'b0, count0_o}, 32'd2);
    check("stall_data0", data0_o, 32'h11);
    to_post();
    // consumer resumes; ready_o stays low while full even with ready0_i high
    ready0_i = 1'b1; valid_i = 1'b1; select_i = 1'b0; data_i = 32'h33;
    @(negedge clk_i);
    check("full_ready_lo", {31'b0, ready_o}, 32'd0);
    to_post();
    @(negedge clk_i);
    check("refill_ready", {31'b0, ready_o}, 32'd1);
    check("refill_count0", {30'b0, count0_o}, 32'd1);
    exp0_q.push_back(32'h33);
    to_post();
    valid_i = 1'b0;
    @(negedge clk_i);
    check("pushpop_count0", {30'b0, count0_o}, 32'd1);
    check("after_data0", data0_o, 32'h33);
    to_post();

    // channel 0 full, channel 1 still accepts
    ready0_i = 1'b0;
    push_word(1'b0, 32'h77, 1'b1);
    push_word(1'b0, 32'h88, 1'b1);
    push_word(1'b1, 32'h44, 1'b1);
    @(negedge clk_i);
    check("cross_data1", data1_o, 32'h44);
    check("cross_count0", {30'b0, count0_o}, 32'd2);
    check("cross_data0", data0_o, 32'h77);
    to_post();

    // push and pop same channel keep count
    ready1_i = 1'b0;
    push_word(1'b1, 32'h55, 1'b1);
    ready1_i = 1'b1;
    push_word(1'b1, 32'h66, 1'b1);
    @(negedge clk_i);
    check("same_count1", {30'b0, count1_o}, 32'd1);
    check("same_data1", data1_o, 32'h66);
    to_post();

    // both full, then reset with handshakes live
    ready1_i = 1'b0;
    push_word(1'b1, 32'h99, 1'b1);
    push_word(1'b1, 32'hAA, 1'b1);
    select_i = 1'b1;
    @(negedge clk_i);
    check("both_count1", {30'b0, count1_o}, 32'd2);
    check("full1_ready", {31'b0, ready_o}, 32'd0);
    to_post();
    rst_i = 1'b1; ready0_i = 1'b1; ready1_i = 1'b1;
    valid_i = 1'b1; select_i = 1'b0; data_i = 32'hDEAD0000;
    to_post();
    rst_i = 1'b0; valid_i = 1'b0;
    exp0_q.delete(); exp1_q.delete();
    @(negedge clk_i);
    check("mid_rst_valid0", {31'b0, valid0_o}, 32'd0);
    check("mid_rst_valid1", {31'b0, valid1_o}, 32'd0);
    check("mid_rst_count0", {30'b0, count0_o}, 32'd0);
    check("mid_rst_count1", {30'b0, count1_o}, 32'd0);
    check("mid_rst_ready", {31'b0, ready_o}, 32'd1);
    to_post();
    push_word(1'b1, 32'hC0FFEE01, 1'b1);
    @(negedge clk_i);
    check("post_rst_count0", {30'b0, count0_o}, 32'd0);
    check("post_rst_data1", data1_o, 32'hC0FFEE01);
    to_post();

    // idle input side must not disturb buffers
    ready0_i = 1'b0;
    push_word(1'b0, 32'hD1D1D1D1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      select_i = i[0];
      data_i   = 32'h1000_0000 + i;
      @(negedge clk_i);
      check("idle_count0", {30'b0, count0_o}, 32'd1);
      check("idle_count1", {30'b0, count1_o}, 32'd0);
      check("idle_valid1", {31'b0, valid1_o}, 32'd0);
      check("idle_data0", data0_o, 32'hD1D1D1D1);
      to_post();
    end
    ready0_i = 1'b1;
    to_post(); to_post();

    @(negedge clk_i);
    check("end_q0_empty", exp0_q.size(), 32'd0);
    check("end_q1_empty", exp1_q.size(), 32'd0);
    check("end_count0", {30'b0, count0_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux_1to2.md
STREAM_DEMUX_1TO2 -- requirements
Module: stream_demux_1to2

Interface
REQ-001 Parameter size, default 32, SHALL set the data width of the input and both output channels.
REQ-002 Parameter depth, default 2, SHALL set the entry count of each output channel buffer; only 2 is required to be supported.
REQ-003 clk_i  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 data_i  input  size  incoming word.
REQ-006 valid_i  input  1  data_i/select_i valid.
REQ-007 select_i  input  1  destination: 0 routes to channel 0, 1 routes to channel 1.
REQ-008 ready_o  output  1  input word accepted this cycle when high together with valid_i.
REQ-009 data0_o / data1_o  output  size  head word of channel 0 / channel 1 buffer.
REQ-010 valid0_o / valid1_o  output  1  channel buffer non-empty.
REQ-011 ready0_i / ready1_i  input  1  downstream consumer accepts head word.
REQ-012 count0_o / count1_o  output  2  current occupancy of each channel buffer (0..2).

Function
REQ-013 Input transfer SHALL occur exactly when valid_i && ready_o on a rising edge.
REQ-014 ready_o SHALL equal NOT full of the buffer addressed by select_i; it SHALL NOT depend on same-cycle ready0_i/ready1_i.
REQ-015 An accepted word SHALL be written only into the buffer selected by select_i; the other buffer SHALL be unaffected.
REQ-016 Output transfer on channel N SHALL occur exactly when validN_o && readyN_i on a rising edge.
REQ-017 Latency: a word accepted at edge k into an empty buffer SHALL appear on dataN_o with validN_o high after edge k (visible in cycle k+1); there SHALL be no combinational path from data_i to dataN_o.
REQ-018 Each channel SHALL preserve arrival order (FIFO); no ordering is defined between channels.
REQ-019 dataN_o SHALL be stable while validN_o is high and readyN_i is low.
REQ-020 Simultaneous push and pop on the same non-full channel SHALL leave countN_o unchanged and keep order.
REQ-021 A push and a pop on different channels in the same cycle SHALL both complete.
REQ-022 Full buffer (count 2): ready_o SHALL be low while select_i addresses it, even if readyN_i is high that cycle.
REQ-023 Empty buffer: validN_o SHALL be low; readyN_i SHALL be ignored and count SHALL NOT underflow.
REQ-024 Read/write pointers SHALL be 1 bit each and wrap from 1 to 0.
REQ-025 valid_i low SHALL cause no state change on the input side regardless of select_i or data_i.
REQ-026 countN_o SHALL increment by 1 on push-only, decrement by 1 on pop-only, and hold otherwise.

Reset
REQ-027 While rst_i is high at an edge, all pointers and counts SHALL clear to 0, so valid0_o = valid1_o = 0 and count0_o = count1_o = 0 in the following cycle.
REQ-028 dataN_o SHALL read 0 after reset until the first push to that channel.
REQ-029 Reset asserted mid-operation SHALL discard all buffered words; any transfer handshakes in that cycle SHALL be ignored.
REQ-030 ready_o SHALL be high in the first cycle after reset deasserts.

Structure
REQ-031 Default width 32, depth 2, and the count width SHALL live in the shared CPU package/include with the other datapath constants.
REQ-032 Each channel SHALL be one instance of sub-module demux_fifo2 (push, pop, data in/out, full, empty, count); the top SHALL contain only select decode, ready_o generation, and instantiations.

Verification
REQ-033 After reset, push 0xA0000001 (select 0) then 0xB0000002 (select 1), with both readyN_i high -> each appears on its channel one cycle after acceptance; counts return to 0.
REQ-034 With ready0_i low, push 0x11, 0x22, 0x33 to channel 0 -> 0x11 and 0x22 accepted, ready_o low on 0x33, count0_o = 2; raise ready0_i -> outputs 0x11, then 0x22, then 0x33 is accepted.
REQ-035 With channel 0 full, select 1 and push 0x44 with ready1_i high -> accepted; data1_o = 0x44 in the next cycle; channel 0 unchanged.
REQ-036 With count1_o = 1 (0x55 buffered), push 0x66 to channel 1 while ready1_i is high -> 0x55 output, count1_o stays 1, data1_o = 0x66 in the next cycle.
REQ-037 With both buffers holding 2 words, assert rst_i for 1 cycle -> valid0_o = valid1_o = 0, counts 0, ready_o = 1; the next push appears unchanged on the correct channel.
REQ-038 Hold valid_i low and toggle select_i/data_i for 10 cycles -> no count change and no validN_o assertion.
